// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: takes a 4-bit two's-complement ALU result, converts it to
// sign-magnitude for a two-digit seven-segment display (sign digit plus
// magnitude digit), and time-multiplexes the two digit enables.
//
// Optional feature macro: SEG_OVF_BLINK_EN
//   When defined, the overflow flag of the last accepted result is latched.
//   While the latch is set, both digit enables are blanked during the half of
//   the blink period selected by wrap-counter bit BLINK_SHIFT.
//   When undefined, i_overflow is ignored and the display never blanks.
module seg_scan_ctrl #(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_SHIFT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [3:0] i_result,
    input  logic       i_overflow,
    output logic       o_ready,
    output logic       o_signbit,
    output logic [3:0] o_seg_in,
    output logic [1:0] o_dig_sel,
    output logic [7:0] o_sign_seg
);

    localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                WRAP_W    = BLINK_SHIFT + 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Conversion FSM: IDLE accepts a result, CONV spends one cycle producing
    // sign-magnitude and then returns to IDLE.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        res_q,   res_d;
    logic              sign_q,  sign_d;
    logic [3:0]        mag_q,   mag_d;
    logic [SCAN_W-1:0] scan_q,  scan_d;
    logic [WRAP_W-1:0] wrap_q,  wrap_d;
    logic [1:0]        dig_q,   dig_d;

    logic              accept;
    logic              scan_wrap;
    logic [3:0]        mag_conv;

    // Handshake: a result transfers in a cycle where i_valid and o_ready are
    // both 1; i_valid with o_ready=0 is dropped (nothing is queued), and the
    // producer does not need to hold i_result after the transfer cycle.
    // Reset overrides every register below, so an i_valid during rst is lost.
    assign o_ready = (state_q == ST_IDLE);
    assign accept  = i_valid && o_ready;

    // Two's complement to magnitude; 4'b1000 wraps to 4'b1000, i.e. 8.
    assign mag_conv = res_q[3] ? (~res_q + 4'd1) : res_q;

    // Next-state and datapath loads for the conversion FSM.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    res_d   = i_result;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                sign_d  = res_q[3];
                mag_d   = mag_conv;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Conversion FSM and displayed value registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= 4'd0;
            sign_q  <= 1'b0;
            mag_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
        end
    end

    // Scan timing: slot counter, wrap counter and digit-enable rotation.
    always_comb begin
        scan_wrap = (scan_q == SCAN_LAST);
        scan_d    = scan_wrap ? '0 : scan_q + SCAN_W'(1);
        wrap_d    = scan_wrap ? wrap_q + WRAP_W'(1) : wrap_q;
        dig_d     = scan_wrap ? {dig_q[0], dig_q[1]} : dig_q;
    end

    // Scan timing registers; dig_q only ever holds 01 or 10.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            wrap_q <= '0;
            dig_q  <= 2'b01;
        end else begin
            scan_q <= scan_d;
            wrap_q <= wrap_d;
            dig_q  <= dig_d;
        end
    end

`ifdef SEG_OVF_BLINK_EN
    logic ovf_q, ovf_d;

    // Overflow latch follows the flag of each accepted result.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = i_overflow;
        end
    end

    // Overflow latch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_dig_sel = (ovf_q && wrap_q[BLINK_SHIFT]) ? 2'b00 : dig_q;
`else
    logic unused_ovf;
    assign unused_ovf = i_overflow;
    assign o_dig_sel  = dig_q;
`endif

    assign o_signbit  = sign_q;
    assign o_seg_in   = mag_q;
    // Minus sign lights segment g only (active low).
    assign o_sign_seg = sign_q ? 8'b1111_1101 : 8'b1111_1111;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances share one stimulus stream, one with
// SCAN_DIV=4 and one with SCAN_DIV=2 (both BLINK_SHIFT=1), compared every
// cycle against a reference model built from cycle counts and integer
// arithmetic. Honours SEG_OVF_BLINK_EN if defined for the build.
module tb_seg_scan_ctrl;

    localparam int DIV_A = 4;
    localparam int DIV_B = 2;
    localparam int BSH   = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic [3:0] i_result;
    logic       i_overflow;

    always #5 clk = ~clk;

    logic       a_ready, b_ready;
    logic       a_sign,  b_sign;
    logic [3:0] a_seg,   b_seg;
    logic [1:0] a_dig,   b_dig;
    logic [7:0] a_sseg,  b_sseg;

    seg_scan_ctrl #(.SCAN_DIV(DIV_A), .BLINK_SHIFT(BSH)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_overflow (i_overflow),
        .o_ready    (a_ready),
        .o_signbit  (a_sign),
        .o_seg_in   (a_seg),
        .o_dig_sel  (a_dig),
        .o_sign_seg (a_sseg)
    );

    seg_scan_ctrl #(.SCAN_DIV(DIV_B), .BLINK_SHIFT(BSH)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_overflow (i_overflow),
        .o_ready    (b_ready),
        .o_signbit  (b_sign),
        .o_seg_in   (b_seg),
        .o_dig_sel  (b_dig),
        .o_sign_seg (b_sseg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];      // {sign, magnitude} of accepted, not yet shown results
    logic       m_ready = 1'b1;
    logic       m_sign  = 1'b0;
    logic [3:0] m_mag   = 4'd0;
    logic       m_ovf   = 1'b0;
    int         m_k     = 0;   // clock edges since the last reset edge

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] sm_of(input logic [3:0] r);
        int v;
        v = (r >= 4'd8) ? int'(r) - 16 : int'(r);
        if (v < 0) return {1'b1, 4'(-v)};
        return {1'b0, 4'(v)};
    endfunction

    function automatic logic [1:0] exp_dig(input int div);
        int  wraps;
        logic blink;
        wraps = m_k / div;
        blink = m_ovf && (((wraps >> BSH) & 1) == 1);
        if (blink) return 2'b00;
        return ((wraps % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        if (rst) begin
            exp_q.delete();
            m_ready = 1'b1;
            m_sign  = 1'b0;
            m_mag   = 4'd0;
            m_ovf   = 1'b0;
            m_k     = 0;
        end else begin
            m_k++;
            if (exp_q.size() > 0) begin
                {m_sign, m_mag} = exp_q.pop_front();
            end
            if (i_valid && m_ready) begin
                exp_q.push_back(sm_of(i_result));
`ifdef SEG_OVF_BLINK_EN
                m_ovf = i_overflow;
`endif
            end
            m_ready = (exp_q.size() == 0);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] sseg;
        sseg = m_sign ? 8'b1111_1101 : 8'b1111_1111;
        check_val("a_ready",    {7'd0, a_ready}, {7'd0, m_ready});
        check_val("a_signbit",  {7'd0, a_sign},  {7'd0, m_sign});
        check_val("a_seg_in",   {4'd0, a_seg},   {4'd0, m_mag});
        check_val("a_sign_seg", a_sseg,          sseg);
        check_val("a_dig_sel",  {6'd0, a_dig},   {6'd0, exp_dig(DIV_A)});
        check_val("a_dig_both", {7'd0, &a_dig},  8'd0);
        check_val("b_ready",    {7'd0, b_ready}, {7'd0, m_ready});
        check_val("b_signbit",  {7'd0, b_sign},  {7'd0, m_sign});
        check_val("b_seg_in",   {4'd0, b_seg},   {4'd0, m_mag});
        check_val("b_sign_seg", b_sseg,          sseg);
        check_val("b_dig_sel",  {6'd0, b_dig},   {6'd0, exp_dig(DIV_B)});
        check_val("b_dig_both", {7'd0, &b_dig},  8'd0);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic o);
        rst        = r;
        i_valid    = v;
        i_result   = d;
        i_overflow = o;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_result   = 4'd0;
        i_overflow = 1'b0;

        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd7, 1'b1);           // valid during reset is ignored

        step(1'b0, 1'b1, 4'b0101, 1'b0);        // +5 accepted
        step(1'b0, 1'b1, 4'b0011, 1'b0);        // busy: dropped
        idle(3);

        step(1'b0, 1'b1, 4'b1000, 1'b0);        // -8
        idle(3);
        step(1'b0, 1'b1, 4'b1111, 1'b0);        // -1
        idle(3);

        step(1'b0, 1'b1, 4'b1010, 1'b0);        // -6, aborted by reset
        step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(4);

        step(1'b0, 1'b1, 4'b0010, 1'b1);        // overflow set
        idle(24);
        step(1'b0, 1'b1, 4'b0011, 1'b0);        // overflow cleared
        idle(10);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
